// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/DE pipeline register.
// Keeps at most one instruction-memory request in flight, parks a response in
// a one-entry hold buffer when decode cannot take it, and squashes wrong-path
// responses after a taken branch.
// Optional build macro: FETCH_PERF_EN adds saturating perf_fetched and
// perf_discarded counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCsrc,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pcf, pcf_nxt;
  logic [XLEN-1:0]   hold_instr, hold_instr_nxt;
  logic [XLEN-1:0]   hold_pc, hold_pc_nxt;
  logic              hold_v, hold_v_nxt;
  logic [XLEN-1:0]   instr_nxt, pc_nxt;
  logic              valid_nxt;
  logic              resp_deliver;

  // Request only when idle, nothing parked, and fetch is neither stalled nor redirected
  assign imem_req  = (state == S_FETCH) & ~hold_v & ~StallF & ~PCsrc;
  assign imem_addr = pcf;

  // State, fetch PC, hold buffer and IF/DE registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pcf        <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_v     <= 1'b0;
      instrD     <= NOP_INSTR;
      pcD        <= '0;
      validD     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pcf        <= pcf_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_v     <= hold_v_nxt;
      instrD     <= instr_nxt;
      pcD        <= pc_nxt;
      validD     <= valid_nxt;
    end
  end

  // Next-state, PC update, response routing and IF/DE selection
  always_comb begin
    state_nxt      = state;
    pcf_nxt        = pcf;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    hold_v_nxt     = hold_v;
    instr_nxt      = instrD;
    pc_nxt         = pcD;
    valid_nxt      = validD;
    resp_deliver   = 1'b0;

    unique case (state)
      S_FETCH: begin
        // Responses seen here are stale and ignored
        if (PCsrc) begin
          pcf_nxt = br_target;
        end else if (imem_req) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_FETCH;
          if (PCsrc) begin
            pcf_nxt = br_target;
          end else begin
            pcf_nxt      = pcf + XLEN'(4);
            resp_deliver = 1'b1;
          end
        end else if (PCsrc) begin
          pcf_nxt   = br_target;
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (PCsrc) begin
          pcf_nxt = br_target;
        end
        if (imem_rvalid) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    if (PCsrc) begin
      instr_nxt  = NOP_INSTR;
      valid_nxt  = 1'b0;
      hold_v_nxt = 1'b0;
    end else if (StallD) begin
      instr_nxt = instrD;
    end else if (FlushD) begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end else if (hold_v) begin
      instr_nxt  = hold_instr;
      pc_nxt     = hold_pc;
      valid_nxt  = 1'b1;
      hold_v_nxt = 1'b0;
    end else if (resp_deliver) begin
      instr_nxt = imem_rdata;
      pc_nxt    = pcf;
      valid_nxt = 1'b1;
    end else begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end

    // A delivered word that decode does not take this cycle is parked
    if (resp_deliver && (StallD || FlushD || hold_v)) begin
      hold_instr_nxt = imem_rdata;
      hold_pc_nxt    = pcf;
      hold_v_nxt     = 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic resp_discard_c;

  assign resp_discard_c = imem_rvalid &
                          (((state == S_WAIT) & PCsrc) | (state == S_DROP));

  // Saturating delivered/discarded response counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (resp_deliver && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + XLEN'(1);
      end
      if (resp_discard_c && (perf_discarded != '1)) begin
        perf_discarded <= perf_discarded + XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/DE pipeline register for the 3-stage RISC-V core. It owns the fetch PC and issues requests to instruction memory with at most one outstanding. It captures responses into the decode register and obeys `StallF`, `StallD` and `FlushD` from the hazard/forwarding unit. On a taken branch (`PCsrc`) it redirects to the branch target and discards wrong-path responses.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `StallF`  in  1  hold fetch PC and block new requests.
- `StallD`  in  1  hold the IF/DE register.
- `FlushD`  in  1  replace IF/DE contents with a bubble.
- `PCsrc`  in  1  branch/jump taken this cycle.
- `br_target`  in  32  redirect address, valid when `PCsrc`=1.
- `imem_req`  out  1  request strobe; memory accepts whenever it is high.
- `imem_addr`  out  32  request address (word aligned).
- `imem_rvalid`  in  1  response valid. In order, at least 1 cycle after its request.
- `imem_rdata`  in  32  response instruction.
- `instrD`  out  32  decode-stage instruction.
- `pcD`  out  32  PC of `instrD`.
- `validD`  out  1  `instrD` is a real instruction, not a bubble.

## Operation
- Registers: `PCF`, `state`, a 1-entry hold buffer (`hold_instr`, `hold_pc`, `hold_v`), and IF/DE (`instrD`, `pcD`, `validD`).
- `imem_addr` = `PCF`, combinational.
- `imem_req` = (`state`==FETCH) & !`hold_v` & !`StallF` & !`PCsrc`.
- States:
  - FETCH: nothing outstanding. If `imem_req` is high, go to WAIT. If `PCsrc`, `PCF`<=`br_target` and stay in FETCH.
  - WAIT: one request outstanding on the correct path.
    - `imem_rvalid` & `PCsrc`: discard the response, `PCF`<=`br_target`, go to FETCH.
    - `imem_rvalid`, no `PCsrc`: deliver the response (below), `PCF`<=`PCF`+4, go to FETCH.
    - `PCsrc` without `imem_rvalid`: `PCF`<=`br_target`, go to DROP.
  - DROP: one wrong-path request outstanding. On `imem_rvalid`, discard it and go to FETCH. A further `PCsrc` in DROP updates `PCF` and stays in DROP.
- `StallF` does not block capture of an already-outstanding response, and does not block a `PCsrc` redirect.
- Deliver:
  - If the IF/DE register loads this cycle, the response goes straight to IF/DE.
  - Otherwise it goes to the hold buffer (`hold_v`<=1).
- IF/DE update, in priority order:
  1. `PCsrc`: bubble (`instrD`=`NOP_INSTR`, `validD`=0), `hold_v`<=0.
  2. `StallD`: hold the current contents. This applies even when `FlushD` is also high.
  3. `FlushD`: bubble.
  4. `hold_v`: load from the hold buffer, `hold_v`<=0.
  5. Delivered response: load it.
  6. Otherwise: bubble.
- `PCF`+4 wraps modulo 2^32.
- Any `imem_rvalid` seen in FETCH is ignored, e.g. stale after reset.

## Timing
- Reset (asynchronous, immediate) sets:
  - `PCF`=`RESET_PC`, state FETCH, `hold_v`=0.
  - `instrD`=`NOP_INSTR`, `pcD`=0, `validD`=0.
  - `imem_req` is therefore high in the first cycle after `rst_n` rises.
- Latency: with a 1-cycle memory, request at cycle N, response at N+1, `instrD` visible at N+2.
- Throughput is one instruction per 2 cycles, because there is at most one outstanding request.
- Redirect penalty: `PCsrc` at cycle N gives a request to `br_target` at N+1 when idle. When a request is outstanding, that request is issued the cycle after its response returns.
- Reset asserted mid-WAIT or mid-DROP abandons the outstanding request. Instruction memory shares `rst_n`.

## Configuration
- `FETCH_PERF_EN` defined: adds two outputs, each 32 bits, reset to 0, saturating at all-ones:
  - `perf_fetched`: responses delivered.
  - `perf_discarded`: responses dropped in WAIT or DROP.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist.

## Test plan
- Reset release, 1-cycle memory returning 32'hA0+addr. Required: `imem_addr` sequence 0,4,8. `instrD` at cycle 2 = 32'hA0, `validD`=1, `pcD`=0.
- `StallD` high for 3 cycles while a response returns. Required: response held in the hold buffer, `imem_req` low, and `instrD` updates one cycle after `StallD` falls with the held word.
- `PCsrc` with `br_target`=32'h100 while in WAIT, with a 3-cycle memory. Required: DROP entered, stale response discarded, next request address 32'h100, IF/DE shows a bubble.
- `FlushD`=1 with `StallD`=0. Required: `instrD`=32'h0000_0013 and `validD`=0 next cycle. With `FlushD`=`StallD`=1: contents unchanged.
- `PCF`=32'hFFFF_FFFC with response accepted. Required: next `imem_addr`=32'h0000_0000.
- `rst_n` pulsed low during WAIT. Required: outputs reset immediately; a late `imem_rvalid` is ignored; fetch restarts at `RESET_PC`.
